// File: rtl/neureka_double_infeat_buffer_ctrl_pkg.sv
// Shared types for the double input-feature buffer ping-pong controller.
// Provides the per-bank state encoding, the configuration payload and the
// status-flag bundle exchanged between the controller and its bank FSMs.
package neureka_double_infeat_buffer_ctrl_pkg;

    localparam int unsigned FILL_LEN_W_DEF = 16;
    localparam int unsigned PASS_W_DEF     = 8;
    localparam int unsigned NUM_BANKS      = 2;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    typedef struct packed {
        logic [FILL_LEN_W_DEF-1:0] fill_len;
        logic [PASS_W_DEF-1:0]     passes;
    } ctrl_double_infeat_buffer_ctrl_t;

    typedef struct packed {
        logic                 wr_ready;
        logic                 rd_valid;
        logic [NUM_BANKS-1:0] bank_full;
        logic                 idle;
        logic                 err;
    } flags_t;

endpackage

// File: rtl/neureka_pingpong_bank_state.sv
// Occupancy FSM for one bank of the ping-pong input-feature buffer.
// Ports:
//   clk, rst       clock and synchronous active-high flush (reset/clear/start)
//   set_fill       first beat accepted into an EMPTY bank
//   set_full       last beat of the fill accepted
//   release_bank   engine finished the final pass over this bank
//   state          current bank state
module neureka_pingpong_bank_state
    import neureka_double_infeat_buffer_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        set_fill,
    input  logic        set_full,
    input  logic        release_bank,
    output bank_state_e state
);

    bank_state_e state_q;
    bank_state_e state_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BANK_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; release and fill events never target the same bank in one cycle
    always_comb begin
        state_d = state_q;
        if (release_bank) begin
            state_d = BANK_EMPTY;
        end else if (set_full) begin
            state_d = BANK_FULL;
        end else if (set_fill) begin
            state_d = BANK_FILLING;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/neureka_double_infeat_buffer_ctrl.sv
// Ping-pong bank controller for the double input-feature buffer.
// The streamer fills the bank at wr_sel while the engine reads the bank at
// rd_sel; each selector toggles only on its own completion.
// Ports:
//   clk_i, rst_i, clear_i      clock, sync reset, sync soft clear
//   enable_i                   freezes state when low (start/clear/reset still act)
//   start_i, cfg_*_i           latch config, empty both banks, start running
//   wr_beat_i / wr_ready_o     fill beat handshake, wr_sel_o bank select
//   rd_pass_done_i / rd_*_o    pass completion, read bank select and status
//   bank_full_o, idle_o, err_o status flags
module neureka_double_infeat_buffer_ctrl
    import neureka_double_infeat_buffer_ctrl_pkg::*;
#(
    parameter int unsigned FILL_LEN_W = FILL_LEN_W_DEF,
    parameter int unsigned PASS_W     = PASS_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic [FILL_LEN_W-1:0] cfg_fill_len_i,
    input  logic [PASS_W-1:0]     cfg_passes_i,
    input  logic                  wr_beat_i,
    output logic                  wr_ready_o,
    output logic                  wr_sel_o,
    output logic                  rd_valid_o,
    output logic                  rd_sel_o,
    input  logic                  rd_pass_done_i,
    output logic                  rd_last_pass_o,
    output logic [NUM_BANKS-1:0]  bank_full_o,
    output logic                  idle_o,
    output logic                  err_o
);

    logic                  running_q;
    logic                  wr_sel_q;
    logic                  rd_sel_q;
    logic [FILL_LEN_W-1:0] fill_cnt_q;
    logic [FILL_LEN_W-1:0] len_q;
    logic [PASS_W-1:0]     pass_cnt_q;
    logic [PASS_W-1:0]     passes_q;
    logic                  err_q;

    bank_state_e           bank_state [NUM_BANKS];
    flags_t                flags_c;

    logic                  flush_c;
    logic                  wr_fire_c;
    logic                  rd_fire_c;
    logic                  wr_viol_c;
    logic                  rd_viol_c;
    logic                  fill_last_c;
    logic                  pass_last_c;

    // Status flags derived from bank states
    always_comb begin
        flags_c           = '0;
        flags_c.bank_full = {bank_state[1] == BANK_FULL, bank_state[0] == BANK_FULL};
        flags_c.wr_ready  = running_q && (bank_state[wr_sel_q] != BANK_FULL);
        flags_c.rd_valid  = (bank_state[rd_sel_q] == BANK_FULL);
        flags_c.idle      = !running_q ||
                            ((bank_state[0] == BANK_EMPTY) && (bank_state[1] == BANK_EMPTY));
        flags_c.err       = err_q;
    end

    // Handshake qualification; a flush cycle swallows any concurrent event
    always_comb begin
        flush_c     = rst_i || clear_i || start_i;
        wr_fire_c   = !flush_c && enable_i && wr_beat_i && flags_c.wr_ready;
        rd_fire_c   = !flush_c && enable_i && rd_pass_done_i && flags_c.rd_valid;
        wr_viol_c   = !flush_c && enable_i && wr_beat_i && !flags_c.wr_ready;
        rd_viol_c   = !flush_c && enable_i && rd_pass_done_i && !flags_c.rd_valid;
        fill_last_c = (fill_cnt_q == len_q - FILL_LEN_W'(1));
        pass_last_c = (pass_cnt_q == passes_q - PASS_W'(1));
    end

    // One occupancy FSM per bank
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic sel_wr;
        logic sel_rd;
        assign sel_wr = (wr_sel_q == 1'(b));
        assign sel_rd = (rd_sel_q == 1'(b));

        neureka_pingpong_bank_state u_bank (
            .clk          (clk_i),
            .rst          (flush_c),
            .set_fill     (wr_fire_c && sel_wr && !fill_last_c),
            .set_full     (wr_fire_c && sel_wr && fill_last_c),
            .release_bank (rd_fire_c && sel_rd && pass_last_c),
            .state        (bank_state[b])
        );
    end

    // Counters, selectors, configuration and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            running_q  <= 1'b0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            fill_cnt_q <= '0;
            pass_cnt_q <= '0;
            len_q      <= '0;
            passes_q   <= '0;
            err_q      <= 1'b0;
        end else if (start_i) begin
            running_q  <= 1'b1;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            fill_cnt_q <= '0;
            pass_cnt_q <= '0;
            // A zero length or pass count would never complete; treat it as one
            len_q      <= (cfg_fill_len_i == '0) ? FILL_LEN_W'(1) : cfg_fill_len_i;
            passes_q   <= (cfg_passes_i == '0) ? PASS_W'(1) : cfg_passes_i;
            err_q      <= 1'b0;
        end else begin
            if (wr_fire_c) begin
                if (fill_last_c) begin
                    fill_cnt_q <= '0;
                    wr_sel_q   <= !wr_sel_q;
                end else begin
                    fill_cnt_q <= fill_cnt_q + FILL_LEN_W'(1);
                end
            end
            if (rd_fire_c) begin
                if (pass_last_c) begin
                    pass_cnt_q <= '0;
                    rd_sel_q   <= !rd_sel_q;
                end else begin
                    pass_cnt_q <= pass_cnt_q + PASS_W'(1);
                end
            end
            if (wr_viol_c || rd_viol_c) begin
                err_q <= 1'b1;
            end
        end
    end

    assign wr_ready_o     = flags_c.wr_ready;
    assign wr_sel_o       = wr_sel_q;
    assign rd_valid_o     = flags_c.rd_valid;
    assign rd_sel_o       = rd_sel_q;
    assign rd_last_pass_o = flags_c.rd_valid && pass_last_c;
    assign bank_full_o    = flags_c.bank_full;
    assign idle_o         = flags_c.idle;
    assign err_o          = flags_c.err;

endmodule

// File: tb/tb_neureka_double_infeat_buffer_ctrl.sv
// Scenario bench for the ping-pong input-feature buffer controller.
// Expected output vectors are hand-derived and queued with each stimulus
// cycle; each scenario drains its queue against what the controller showed.
// Vector order: {wr_ready, wr_sel, rd_valid, rd_sel, rd_last_pass, bank_full[1:0], idle, err}
module tb_neureka_double_infeat_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        enable;
    logic        start;
    logic [15:0] cfg_fill_len;
    logic [7:0]  cfg_passes;
    logic        wr_beat;
    logic        wr_ready;
    logic        wr_sel;
    logic        rd_valid;
    logic        rd_sel;
    logic        rd_pass_done;
    logic        rd_last_pass;
    logic [1:0]  bank_full;
    logic        idle;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [8:0]  exp_q [$];
    logic [8:0]  obs_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    neureka_double_infeat_buffer_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .enable_i       (enable),
        .start_i        (start),
        .cfg_fill_len_i (cfg_fill_len),
        .cfg_passes_i   (cfg_passes),
        .wr_beat_i      (wr_beat),
        .wr_ready_o     (wr_ready),
        .wr_sel_o       (wr_sel),
        .rd_valid_o     (rd_valid),
        .rd_sel_o       (rd_sel),
        .rd_pass_done_i (rd_pass_done),
        .rd_last_pass_o (rd_last_pass),
        .bank_full_o    (bank_full),
        .idle_o         (idle),
        .err_o          (err)
    );

    function automatic logic [8:0] mk(input logic wrr, input logic ws, input logic rv,
                                      input logic rs, input logic rl, input logic [1:0] bf,
                                      input logic idl, input logic er);
        return {wrr, ws, rv, rs, rl, bf, idl, er};
    endfunction

    // Drive one cycle, queue its expectation, capture the post-edge outputs
    task automatic step(input logic r, input logic c, input logic e, input logic s,
                        input logic b, input logic p, input logic [8:0] expv, input string tag);
        rst          = r;
        clear        = c;
        enable       = e;
        start        = s;
        wr_beat      = b;
        rd_pass_done = p;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        obs_q.push_back({wr_ready, wr_sel, rd_valid, rd_sel, rd_last_pass,
                         bank_full, idle, err});
        rst          = 1'b0;
        clear        = 1'b0;
        start        = 1'b0;
        wr_beat      = 1'b0;
        rd_pass_done = 1'b0;
        enable       = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] e, o;
        string      t;
        logic [8:0] rv = mk(0, 0, 0, 0, 0, 2'b00, 1, 0);
        step(1, 0, 1, 0, 0, 0, rv, "rst_cycle0");
        step(1, 0, 1, 0, 0, 0, rv, "rst_cycle1");
        step(0, 0, 1, 0, 0, 0, rv, "idle_after_rst");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL test_reset %s: got %b expected %b", t, o, e);
            end
        end
    endtask

    task automatic test_fill_to_full();
        logic [8:0] e, o;
        string      t;
        cfg_fill_len = 16'd4;
        cfg_passes   = 8'd2;
        step(0, 0, 1, 1, 0, 0, mk(1, 0, 0, 0, 0, 2'b00, 1, 0), "start");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, 1, 0, mk(1, 0, 0, 0, 0, 2'b00, 0, 0), "bank0_filling");
        step(0, 0, 1, 0, 1, 0, mk(1, 1, 1, 0, 0, 2'b01, 0, 0), "bank0_full");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, 1, 0, mk(1, 1, 1, 0, 0, 2'b01, 0, 0), "bank1_filling");
        step(0, 0, 1, 0, 1, 0, mk(0, 0, 1, 0, 0, 2'b11, 0, 0), "both_full");
        step(0, 0, 1, 0, 1, 0, mk(0, 0, 1, 0, 0, 2'b11, 0, 1), "overflow_err");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL test_fill_to_full %s: got %b expected %b", t, o, e);
            end
        end
    endtask

    task automatic test_release();
        logic [8:0] e, o;
        string      t;
        step(0, 0, 1, 0, 0, 1, mk(0, 0, 1, 0, 1, 2'b11, 0, 1), "pass1_last_flag");
        step(0, 0, 1, 0, 0, 1, mk(1, 0, 1, 1, 0, 2'b10, 0, 1), "bank0_released");
        step(0, 0, 1, 0, 1, 0, mk(1, 0, 1, 1, 0, 2'b10, 0, 1), "bank0_refill_start");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL test_release %s: got %b expected %b", t, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e, o;
        string      t;
        cfg_fill_len = 16'd1;
        cfg_passes   = 8'd1;
        step(0, 0, 1, 1, 0, 0, mk(1, 0, 0, 0, 0, 2'b00, 1, 0), "start_1_1");
        step(0, 0, 1, 0, 1, 0, mk(1, 1, 1, 0, 1, 2'b01, 0, 0), "single_beat_fill");
        step(0, 0, 1, 0, 1, 1, mk(1, 0, 1, 1, 1, 2'b10, 0, 0), "fill_and_release");
        step(0, 0, 1, 0, 1, 1, mk(1, 1, 1, 0, 1, 2'b01, 0, 0), "fill_and_release_2");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL test_back_to_back %s: got %b expected %b", t, o, e);
            end
        end
    endtask

    task automatic test_zero_cfg_and_err();
        logic [8:0] e, o;
        string      t;
        cfg_fill_len = 16'd0;
        cfg_passes   = 8'd0;
        step(0, 0, 1, 1, 0, 0, mk(1, 0, 0, 0, 0, 2'b00, 1, 0), "start_0_0");
        step(0, 0, 1, 0, 0, 1, mk(1, 0, 0, 0, 0, 2'b00, 1, 1), "underflow_err");
        step(0, 0, 1, 1, 0, 0, mk(1, 0, 0, 0, 0, 2'b00, 1, 0), "start_clears_err");
        step(0, 0, 1, 0, 1, 0, mk(1, 1, 1, 0, 1, 2'b01, 0, 0), "zero_len_as_one");
        step(0, 0, 1, 0, 0, 1, mk(1, 1, 0, 1, 0, 2'b00, 1, 0), "zero_pass_as_one");
        step(0, 0, 0, 0, 1, 1, mk(1, 1, 0, 1, 0, 2'b00, 1, 0), "disabled_dropped");
        step(0, 0, 0, 0, 0, 1, mk(1, 1, 0, 1, 0, 2'b00, 1, 0), "disabled_no_err");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL test_zero_cfg_and_err %s: got %b expected %b", t, o, e);
            end
        end
    endtask

    task automatic test_abort();
        logic [8:0] e, o;
        string      t;
        logic [8:0] rv = mk(0, 0, 0, 0, 0, 2'b00, 1, 0);
        logic [8:0] sv = mk(1, 0, 0, 0, 0, 2'b00, 1, 0);
        logic [8:0] fv = mk(1, 0, 0, 0, 0, 2'b00, 0, 0);
        cfg_fill_len = 16'd4;
        cfg_passes   = 8'd2;
        step(0, 0, 1, 1, 0, 0, sv, "start");
        step(0, 0, 1, 0, 1, 0, fv, "beat1");
        step(0, 0, 1, 0, 1, 0, fv, "beat2");
        step(0, 1, 1, 0, 1, 0, rv, "clear_mid_fill");
        step(0, 0, 1, 1, 0, 0, sv, "restart");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, 1, 0, fv, "fresh_beats");
        step(0, 0, 1, 0, 1, 0, mk(1, 1, 1, 0, 0, 2'b01, 0, 0), "fresh_full");
        step(1, 0, 1, 0, 0, 1, rv, "rst_mid_read");
        step(0, 0, 1, 1, 0, 0, sv, "restart2");
        step(0, 1, 1, 1, 0, 0, rv, "clear_beats_start");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL test_abort %s: got %b expected %b", t, o, e);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        clear        = 1'b0;
        enable       = 1'b1;
        start        = 1'b0;
        wr_beat      = 1'b0;
        rd_pass_done = 1'b0;
        cfg_fill_len = 16'd0;
        cfg_passes   = 8'd0;
        test_reset();
        test_fill_to_full();
        test_release();
        test_back_to_back();
        test_zero_cfg_and_err();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neureka_double_infeat_buffer_ctrl.md
Name: neureka_double_infeat_buffer_ctrl

Overview:
Ping-pong bank controller driving the write/read bank selectors of the double input-feature buffer. The streamer side fills one bank while the engine reads the other. Fill beats come in from the streamer side; pass completions come back from the engine side. The block tracks per-bank state, and emits the write select, the read select, readiness and the full flags.

Parameters:
FILL_LEN_W, 16, width of the beats-per-fill counter and configuration field
PASS_W, 8, width of the reads-per-bank (pass) counter and configuration field

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
clear_i  in  1  synchronous soft clear; same effect as rst_i
enable_i  in  1  gates all state updates except rst_i, clear_i and start_i
start_i  in  1  pulse: latch cfg, empty both banks, set running
cfg_fill_len_i  in  FILL_LEN_W  beats per bank fill
cfg_passes_i  in  PASS_W  engine passes per filled bank before release
wr_beat_i  in  1  one word accepted into the current write bank
wr_ready_o  out  1  current write bank may accept beats
wr_sel_o  out  1  write bank select; feeds ctrl.write
rd_valid_o  out  1  current read bank is full and readable
rd_sel_o  out  1  read bank select; feeds ctrl.read
rd_pass_done_i  in  1  engine finished one pass over the read bank
rd_last_pass_o  out  1  current pass is the final one for this bank
bank_full_o  out  2  per-bank FULL flag
idle_o  out  1  running and both banks EMPTY, or not running
err_o  out  1  sticky protocol-violation flag

Behaviour:
- Per-bank state: EMPTY, FILLING, FULL. Registers: running, wr_sel, rd_sel, fill_cnt, pass_cnt, len_q, passes_q, err.
- Reset and clear: both banks EMPTY, all counters 0, running=0, err=0.
  - Reset values: wr_ready_o=0, wr_sel_o=0, rd_valid_o=0, rd_sel_o=0, rd_last_pass_o=0, bank_full_o=00, idle_o=1, err_o=0.
- start_i (enable-independent):
  - Latches len_q=max(cfg_fill_len_i,1) and passes_q=max(cfg_passes_i,1). Zero is treated as 1.
  - Sets running=1, empties both banks, sets selectors and counters to 0, clears err.
  - If start_i and clear_i are both high, clear wins.
- Combinational outputs:
  - wr_ready_o = running & state[wr_sel]!=FULL.
  - rd_valid_o = state[rd_sel]==FULL.
  - rd_last_pass_o = rd_valid_o & (pass_cnt==passes_q-1).
  - wr_sel_o and rd_sel_o come straight from their registers.
- Write side:
  - A wr_beat_i with wr_ready_o=1 moves an EMPTY bank to FILLING and increments fill_cnt.
  - On the beat where fill_cnt==len_q-1: the bank goes FULL, fill_cnt returns to 0, wr_sel toggles. All take effect next cycle.
  - So a bank is readable the cycle after its last beat (latency 1).
- Read side:
  - rd_pass_done_i with rd_valid_o=1 increments pass_cnt.
  - On the last pass: the bank goes EMPTY, pass_cnt returns to 0, rd_sel toggles. The bank is writable the next cycle.
- Full/empty boundaries:
  - Both banks FULL: wr_ready_o=0.
  - Both banks EMPTY or FILLING: rd_valid_o=0.
  - wr_sel and rd_sel are never forced. Each toggles only on its own completion, so the banks strictly alternate.
- Simultaneous events:
  - A fill completion on one bank and a release of the other bank in the same cycle both take effect.
  - With len_q=1 a single beat both starts and completes the fill.
- Violations:
  - wr_beat_i while wr_ready_o=0, or rd_pass_done_i while rd_valid_o=0: the event is ignored and err is set.
  - err stays set until start, clear or reset.
- enable_i=0 freezes all state. Beats and pass-dones arriving in that cycle are dropped without setting err.
- Reset or clear mid-fill or mid-read abandons the bank contents. No partial-completion flags are produced.

Decomposition:
- Shared package: bank state enum (EMPTY/FILLING/FULL), a ctrl_double_infeat_buffer_ctrl_t cfg struct (fill_len, passes), and a flags struct (wr_ready, rd_valid, bank_full, idle, err).
- One natural sub-module, neureka_pingpong_bank_state: one instance per bank, holding the 3-state FSM with set_fill, set_full and release inputs.
- Counters and selectors stay in the top level.

Test Plan:
1. Reset, then start_i with len=4 and passes=2 → wr_ready_o=1 and idle_o=1. After 4 beats, bank_full_o=01 and rd_valid_o=1 with rd_sel_o=0 in the next cycle, and wr_sel_o=1.
2. Continue with 4 more beats and no pass-dones → bank_full_o=11 and wr_ready_o=0. A fifth beat sets err_o=1 and bank_full_o stays 11.
3. From the both-FULL state, two rd_pass_done_i pulses → rd_last_pass_o=1 on the second pass. Next cycle bank0 is EMPTY, rd_sel_o=1, wr_ready_o=1 and wr_sel_o=0.
4. len=1, passes=1, with a beat on bank1 and a pass-done on bank0 in the same cycle → next cycle bank_full_o=10 and both selectors toggle.
5. cfg_fill_len_i=0 and cfg_passes_i=0 → behaves as 1 and 1. rd_pass_done_i with rd_valid_o=0 sets err_o, and a following start_i clears it.
6. Assert rst_i (or clear_i) after 2 of 4 beats → next cycle all outputs are at reset values. A subsequent start_i requires 4 fresh beats before rd_valid_o=1.
